// File: rtl/dbus_wb_if.sv
// Data-side bus interface: turns the MEM stage's single-cycle memory request into a
// Wishbone B3 classic master cycle and holds the pipeline until the slave acknowledges.
// One outstanding cycle at most; cyc and stb are driven from the same register.
// Optional ack watchdog enabled by defining DBUS_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module dbus_wb_if #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i,
  output logic                bus_err_o
);

  localparam int unsigned SelW = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StWaitStall
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wb_adr_q;
  logic [DATA_W-1:0]   wb_dat_q;
  logic                wb_we_q;
  logic [SelW-1:0]     wb_sel_q;
  logic                wb_cyc_q;
  logic [DATA_W-1:0]   rd_buf_q;
  logic                timeout_hit;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] tmo_cnt_q;
  logic            bus_err_q;

  // The last ack-less BUSY cycle before the limit is the abort cycle.
  assign timeout_hit = (state_q == StBusy) && !wb_ack_i && !flush_i &&
                       (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: zero while idle so it starts from 0 on entry to BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (state_q != StBusy) begin
        tmo_cnt_q <= '0;
      end else if (!wb_ack_i) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // Bus-cycle FSM with registered Wishbone outputs and read-data buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_we_q  <= 1'b0;
      wb_sel_q <= '0;
      wb_cyc_q <= 1'b0;
      rd_buf_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_q <= cpu_addr_i;
            wb_dat_q <= cpu_data_i;
            wb_we_q  <= cpu_we_i;
            wb_sel_q <= cpu_sel_i;
            wb_cyc_q <= 1'b1;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          // Flush beats ack; ack beats the watchdog.
          if (flush_i || wb_ack_i || timeout_hit) begin
            wb_adr_q <= '0;
            wb_dat_q <= '0;
            wb_we_q  <= 1'b0;
            wb_sel_q <= '0;
            wb_cyc_q <= 1'b0;
            if (!flush_i && wb_ack_i) begin
              rd_buf_q <= wb_dat_i;
              state_q  <= (stall_i != '0) ? StWaitStall : StIdle;
            end else begin
              rd_buf_q <= '0;
              state_q  <= StIdle;
            end
          end
        end
        StWaitStall: begin
          if (flush_i) begin
            rd_buf_q <= '0;
            state_q  <= StIdle;
          end else if (stall_i == '0) begin
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall request and read-data return, with a zero-latency bypass in the ack cycle.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state_q)
        StIdle:      stallreq_o = cpu_ce_i & ~flush_i;
        StBusy: begin
          stallreq_o = ~wb_ack_i & ~flush_i & ~timeout_hit;
          if (wb_ack_i && !flush_i) begin
            cpu_data_o = wb_dat_i;
          end
        end
        StWaitStall: cpu_data_o = rd_buf_q;
        default:     stallreq_o = 1'b0;
      endcase
    end
  end

  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_we_o  = wb_we_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_stb_o = wb_cyc_q;
  assign wb_cyc_o = wb_cyc_q;

endmodule

// File: tb/tb_dbus_wb_if.sv
// Directed bench for dbus_wb_if: inputs change 1 time unit after a rising edge,
// outputs are checked 1 time unit later, well clear of the next edge.
module tb_dbus_wb_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_wb_if #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .bus_err_o  (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Full Wishbone master state in one go.
  task automatic chk_wb(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input logic [3:0] sel, input logic cyc);
    chk({tag, ".adr"}, wb_adr_o, adr);
    chk({tag, ".dat"}, wb_dat_o, dat);
    chk({tag, ".we"},  {31'd0, wb_we_o}, {31'd0, we});
    chk({tag, ".sel"}, {28'd0, wb_sel_o}, {28'd0, sel});
    chk({tag, ".stb"}, {31'd0, wb_stb_o}, {31'd0, cyc});
    chk({tag, ".cyc"}, {31'd0, wb_cyc_o}, {31'd0, cyc});
  endtask

  task automatic chk_cpu(input string tag, input logic stallreq, input logic [31:0] data);
    chk({tag, ".stallreq"}, {31'd0, stallreq_o}, {31'd0, stallreq});
    chk({tag, ".cpu_data"}, cpu_data_o, data);
  endtask

  task automatic req(input logic ce, input logic we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] data);
    cpu_ce_i   = ce;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_sel_i  = sel;
    cpu_data_i = data;
  endtask

  initial begin
    rst = 1'b1; stall_i = '0; flush_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset state, including combinational outputs held low while rst is high.
    tick(); tick();
    cpu_ce_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    settle();
    chk_wb("reset", 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    chk_cpu("reset", 1'b0, 32'h0);
    chk("reset.bus_err", {31'd0, bus_err_o}, 32'd0);
    cpu_ce_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
    rst = 1'b0;
    tick();
    chk_cpu("idle", 1'b0, 32'h0);

    // Read with ack in the second BUSY cycle.
    req(1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0);
    settle();
    chk_cpu("rd.idle", 1'b1, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk_wb("rd.busy1", 32'h0000_0100, 32'h0, 1'b0, 4'b1111, 1'b1);
    chk_cpu("rd.busy1", 1'b1, 32'h0);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    settle();
    chk_cpu("rd.ack", 1'b0, 32'hDEAD_BEEF);
    chk_wb("rd.ack", 32'h0000_0100, 32'h0, 1'b0, 4'b1111, 1'b1);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = '0;
    settle();
    chk_wb("rd.done", 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    chk_cpu("rd.done", 1'b0, 32'h0);

    // Byte write with three wait states.
    req(1'b1, 1'b1, 32'h0000_0203, 4'b0001, 32'h5555_5555);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_wb("wr.wait", 32'h0000_0203, 32'h5555_5555, 1'b1, 4'b0001, 1'b1);
      chk_cpu("wr.wait", 1'b1, 32'h0);
      tick();
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_0BAD;
    settle();
    chk_wb("wr.ack", 32'h0000_0203, 32'h5555_5555, 1'b1, 4'b0001, 1'b1);
    chk("wr.ack.stallreq", {31'd0, stallreq_o}, 32'd0);
    tick();
    wb_ack_i = 1'b0;
    settle();
    chk_wb("wr.done", 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);

    // Ack while the pipeline is stalled elsewhere: data held in the buffer.
    req(1'b1, 1'b0, 32'h0000_0300, 4'b1111, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stall_i = 6'b001111; wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    settle();
    chk_cpu("ws.ack", 1'b0, 32'h1234_5678);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'hAAAA_AAAA;
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0999;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_cpu("ws.hold", 1'b0, 32'h1234_5678);
      chk("ws.hold.stb", {31'd0, wb_stb_o}, 32'd0);
      tick();
    end
    // Stray ack in WAIT_STALL must not bypass.
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1; stall_i = '0;
    settle();
    chk_cpu("ws.release", 1'b0, 32'h1234_5678);
    tick();
    wb_ack_i = 1'b0;
    settle();
    chk_cpu("ws.idle", 1'b0, 32'h0);
    chk("ws.idle.stb", {31'd0, wb_stb_o}, 32'd0);

    // Flush in the second BUSY cycle, then a late ack that must be ignored.
    req(1'b1, 1'b0, 32'h0000_0400, 4'b1111, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk_cpu("fl.busy1", 1'b1, 32'h0);
    tick();
    flush_i = 1'b1;
    settle();
    chk_cpu("fl.busy2", 1'b0, 32'h0);
    tick();
    flush_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    settle();
    chk_wb("fl.after", 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    chk_cpu("fl.late_ack", 1'b0, 32'h0);
    tick();
    wb_ack_i = 1'b0;
    settle();
    chk_cpu("fl.idle", 1'b0, 32'h0);

    // Flush in IDLE suppresses issue.
    cpu_ce_i = 1'b1; flush_i = 1'b1;
    settle();
    chk_cpu("fl.idle_req", 1'b0, 32'h0);
    tick();
    cpu_ce_i = 1'b0; flush_i = 1'b0;
    settle();
    chk("fl.idle_req.stb", {31'd0, wb_stb_o}, 32'd0);

    // Zero byte-enables still issue a cycle.
    req(1'b1, 1'b1, 32'h0000_0501, 4'b0000, 32'h0000_00A5);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk_wb("sel0", 32'h0000_0501, 32'h0000_00A5, 1'b1, 4'b0000, 1'b1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;

    // Reset while BUSY.
    req(1'b1, 1'b1, 32'h0000_0600, 4'b1100, 32'h7777_8888);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk("rs.busy.stb", {31'd0, wb_stb_o}, 32'd1);
    rst = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_0000;
    settle();
    chk_cpu("rs.asserted", 1'b0, 32'h0);
    tick();
    settle();
    chk_wb("rs.after", 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    tick();
    settle();
    chk_cpu("rs.idle_ack", 1'b0, 32'h0);
    chk("rs.idle.stb", {31'd0, wb_stb_o}, 32'd0);
    wb_ack_i = 1'b0; wb_dat_i = '0;

`ifdef DBUS_TIMEOUT_EN
    // Slave never acks: abort in the eighth BUSY cycle, error pulse afterwards.
    req(1'b1, 1'b0, 32'h0000_0700, 4'b1111, 32'h0);
    tick();
    req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      settle();
      chk_cpu("to.wait", 1'b1, 32'h0);
      chk("to.wait.stb", {31'd0, wb_stb_o}, 32'd1);
      chk("to.wait.err", {31'd0, bus_err_o}, 32'd0);
      tick();
    end
    settle();
    chk_cpu("to.abort", 1'b0, 32'h0);
    tick();
    settle();
    chk_wb("to.after", 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
    chk("to.err_pulse", {31'd0, bus_err_o}, 32'd1);
    tick();
    settle();
    chk("to.err_clear", {31'd0, bus_err_o}, 32'd0);
`else
    chk("no_timeout.bus_err", {31'd0, bus_err_o}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_wb_if.md
Name: dbus_wb_if

Overview:
- Data-side bus interface directly downstream of the MEM stage.
- Converts the single-cycle memory request (ce/we/sel/addr/data) into a Wishbone B3 classic master cycle.
- Holds the pipeline through stallreq_o until the slave acknowledges, then returns read data to MEM for byte/half extraction, LL/SC and LWL/LWR merge.
- Handles pipeline stall and flush from the ctrl block.

Parameters:
- ADDR_W, 32, width of address bus.
- DATA_W, 32, width of data bus (byte lanes = DATA_W/8).
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- stall_i  in  6  pipeline stall vector from ctrl.
- flush_i  in  1  pipeline flush (exception) from ctrl.
- cpu_ce_i  in  1  memory request valid from MEM.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  byte address (already word-aligned by MEM for LWL/LWR/SWL/SWR).
- cpu_sel_i  in  DATA_W/8  byte enables; bit3 = bits[31:24] (big-endian lane order).
- cpu_data_i  in  DATA_W  write data.
- cpu_data_o  out  DATA_W  read data to MEM.
- stallreq_o  out  1  stall request to ctrl.
- wb_adr_o  out  ADDR_W  Wishbone address.
- wb_dat_o  out  DATA_W  Wishbone write data.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  DATA_W/8  Wishbone byte select.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_ack_i  in  1  Wishbone acknowledge.
- bus_err_o  out  1  watchdog abort pulse (feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o all 0.
  - rd_buf=0, bus_err_o=0.
- While rst=1, combinational outputs cpu_data_o=0 and stallreq_o=0.
- Reset mid-cycle drops stb/cyc on the next edge; no completion is reported.
- Registered state machine, states IDLE, BUSY, WAIT_STALL:
  - IDLE:
    - If cpu_ce_i=1 and flush_i=0: register wb_adr_o=cpu_addr_i, wb_dat_o=cpu_data_i, wb_we_o=cpu_we_i, wb_sel_o=cpu_sel_i, wb_stb_o=wb_cyc_o=1; go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - If flush_i=1: clear all wb_* outputs, rd_buf=0, go to IDLE. Flush takes priority over ack.
    - Else if wb_ack_i=1: clear all wb_* outputs; rd_buf=wb_dat_i (write cycles also latch; don't care). Go to WAIT_STALL if stall_i!=0, else to IDLE.
    - Else hold all wb_* outputs stable (Wishbone rule).
  - WAIT_STALL:
    - Hold rd_buf until stall_i==0, then go to IDLE.
    - flush_i=1: rd_buf=0, go to IDLE.
    - No new bus cycle is started in this state.
- stallreq_o (combinational):
  - IDLE: cpu_ce_i & ~flush_i.
  - BUSY: ~wb_ack_i & ~flush_i.
  - WAIT_STALL: 0.
- cpu_data_o (combinational):
  - BUSY with wb_ack_i=1: wb_dat_i (zero-latency bypass).
  - WAIT_STALL: rd_buf.
  - Otherwise: 0.
- Minimum latency: 2 cycles from cpu_ce_i to data (issue edge, then ack in BUSY). The pipeline is stalled for every cycle before ack.
- Only one outstanding cycle. wb_cyc_o==wb_stb_o always. No burst or retry.
- Ack seen in IDLE or WAIT_STALL is ignored.
- cpu_ce_i=1 with cpu_sel_i=0 (misaligned SH/SB default) still issues a cycle with sel=0.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: clear wb_* outputs, rd_buf=0, pulse bus_err_o=1 for one cycle, go to IDLE. The abort cycle reports data 0 and stallreq_o=0.
- Not defined:
  - No counter is built; BUSY waits for ack indefinitely.
  - bus_err_o is tied to 0.

Test Plan:
- Read, 1-cycle ack: cpu_ce_i=1, we=0, addr=0x0000_0100, sel=4'b1111; slave acks the cycle after stb with dat=0xDEAD_BEEF. Required: stallreq_o=1 for 2 cycles; cpu_data_o=0xDEAD_BEEF in the ack cycle; stb/cyc=0 next cycle.
- Byte write, 3 wait states: we=1, addr=0x0000_0203, sel=4'b0001, data=0x5555_5555. Required: wb_* outputs stable for 4 BUSY cycles; release after ack; stallreq_o falls in the ack cycle.
- Ack during external stall: stall_i=6'b001111 held 3 cycles past ack with dat=0x1234_5678. Required: state WAIT_STALL, cpu_data_o=0x1234_5678 throughout, no new stb; then IDLE.
- Flush mid-cycle: flush_i=1 in the 2nd BUSY cycle with ack=0. Required: stb/cyc=0 next edge; stallreq_o=0; cpu_data_o=0; the late ack is ignored.
- Reset mid-cycle: rst=1 while BUSY. Required: all outputs 0 after the edge; state IDLE.
- DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks. Required: abort after 8 BUSY cycles; bus_err_o high 1 cycle; stallreq_o=0.
